ram_port_arbiter: RTL and testbench

Sequencing controller for the single byte-wide RAM/IO bus. It arbitrates between the instruction-fetch requester and the data-memory (load/store) requester, and serialises each 1/2/4-byte access into byte cycles. It absorbs the RAM's one-cycle read latency and honours the system pause signal. It sits between the IF and MEM stages and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

---
 rtl/ram_port_arbiter_pkg.sv | 39 +++
 rtl/ram_port_arbiter_if.sv | 36 +++
 rtl/ram_port_arbiter_byte_seq.sv | 84 ++++++++
 rtl/ram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM/IO port arbiter.
package ram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_e;

   // Byte counts a transaction can carry
   localparam logic [2:0] LEN_1 = 3'd1;
   localparam logic [2:0] LEN_2 = 3'd2;
   localparam logic [2:0] LEN_4 = 3'd4;

   // IO space lives where addr[17:16] == 2'b11
   localparam logic [31:0] IO_MASK = 32'h0003_0000;
   localparam logic [31:0] IO_BASE = 32'h0003_0000;

   // Any length code other than 1 or 2 is a full word
   function automatic logic [2:0] len_decode(input logic [2:0] len);
      logic [2:0] n;
      case (len)
         LEN_1:   n = LEN_1;
         LEN_2:   n = LEN_2;
         default: n = LEN_4;
      endcase
      return n;
   endfunction

   function automatic logic is_io(input logic [31:0] addr);
      return (addr & IO_MASK) == IO_BASE;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-pin bundle seen by the arbiter.
interface ram_port_arbiter_if;
   logic        rdy_in;
   logic        flush_in;
   logic        if_req_in;
   logic [31:0] if_addr_in;
   logic        mem_req_in;
   logic        mem_wr_in;
   logic [31:0] mem_addr_in;
   logic [2:0]  mem_len_in;
   logic [31:0] mem_wdata_in;
   logic [7:0]  ram_din_in;
   logic [7:0]  ram_dout_out;
   logic [31:0] ram_a_out;
   logic        ram_wr_out;
   logic        if_done_out;
   logic [31:0] if_inst_out;
   logic        mem_done_out;
   logic [31:0] mem_rdata_out;
   logic        busy_if_out;
   logic        busy_mem_out;

   modport slave (
      input  rdy_in, flush_in, if_req_in, if_addr_in, mem_req_in, mem_wr_in,
             mem_addr_in, mem_len_in, mem_wdata_in, ram_din_in,
      output ram_dout_out, ram_a_out, ram_wr_out, if_done_out, if_inst_out,
             mem_done_out, mem_rdata_out, busy_if_out, busy_mem_out
   );

   modport master (
      output rdy_in, flush_in, if_req_in, if_addr_in, mem_req_in, mem_wr_in,
             mem_addr_in, mem_len_in, mem_wdata_in, ram_din_in,
      input  ram_dout_out, ram_a_out, ram_wr_out, if_done_out, if_inst_out,
             mem_done_out, mem_rdata_out, busy_if_out, busy_mem_out
   );
endinterface

// File: rtl/ram_port_arbiter_byte_seq.sv
// Byte index / pending-capture counter plus byte-lane assembly and select.
module ram_port_arbiter_byte_seq (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        step_i,
   input  logic        read_i,
   input  logic [7:0]  din_i,
   input  logic [31:0] wdata_i,
   output logic [2:0]  idx_o,
   output logic        pend_o,
   output logic [31:0] asm_o,
   output logic [7:0]  wbyte_o
);
   logic [2:0]  idx_q, idx_d;
   logic        pend_q, pend_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] merged_s;

   // Merge the byte arriving this cycle into lane idx-1 when one is pending
   always_comb begin
      merged_s = asm_q;
      if (pend_q) begin
         case (idx_q)
            3'd1:    merged_s[7:0]   = din_i;
            3'd2:    merged_s[15:8]  = din_i;
            3'd3:    merged_s[23:16] = din_i;
            3'd4:    merged_s[31:24] = din_i;
            default: merged_s = asm_q;
         endcase
      end else begin
         merged_s = asm_q;
      end
   end

   // Store byte lane for the current index
   always_comb begin
      case (idx_q)
         3'd0:    wbyte_o = wdata_i[7:0];
         3'd1:    wbyte_o = wdata_i[15:8];
         3'd2:    wbyte_o = wdata_i[23:16];
         3'd3:    wbyte_o = wdata_i[31:24];
         default: wbyte_o = 8'd0;
      endcase
   end

   // Next index/pending/assembly: capture ignores rdy, issue follows step
   always_comb begin
      idx_d  = idx_q;
      pend_d = pend_q;
      asm_d  = asm_q;
      if (clear_i) begin
         idx_d  = 3'd0;
         pend_d = 1'b0;
         asm_d  = 32'd0;
      end else begin
         asm_d  = merged_s;
         pend_d = 1'b0;
         if (step_i) begin
            idx_d  = idx_q + 3'd1;
            pend_d = read_i;
         end else begin
            idx_d  = idx_q;
         end
      end
   end

   // Counter and assembly registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q  <= 3'd0;
         pend_q <= 1'b0;
         asm_q  <= 32'd0;
      end else begin
         idx_q  <= idx_d;
         pend_q <= pend_d;
         asm_q  <= asm_d;
      end
   end

   assign idx_o  = idx_q;
   assign pend_o = pend_q;
   assign asm_o  = merged_s;
endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto the byte-wide RAM/IO bus.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
(
   input  logic                clk_in,
   input  logic                rst_in,
   ram_port_arbiter_if.slave   bus
);
   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [31:0] base_q, base_d;
   logic [2:0]  len_q, len_d;
   logic        if_done_q, if_done_d;
   logic        mem_done_q, mem_done_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        clear_s, step_s;
   logic [2:0]  idx_s;
   logic        pend_s;
   logic [31:0] asm_s;
   logic [7:0]  wbyte_s;

   ram_port_arbiter_byte_seq u_seq (
      .clk_i   (clk_in),
      .rst_ni  (rst_in),
      .clear_i (clear_s),
      .step_i  (step_s),
      .read_i  (state_q == READ),
      .din_i   (bus.ram_din_in),
      .wdata_i (bus.mem_wdata_in),
      .idx_o   (idx_s),
      .pend_o  (pend_s),
      .asm_o   (asm_s),
      .wbyte_o (wbyte_s)
   );

   // Arbitration, flush abort, completion detection and sequencing control
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      base_d      = base_q;
      len_d       = len_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
      clear_s     = 1'b0;
      step_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.rdy_in && bus.mem_req_in) begin
               state_d = bus.mem_wr_in ? WRITE : READ;
               owner_d = OWN_MEM;
               base_d  = bus.mem_addr_in;
               len_d   = len_decode(bus.mem_len_in);
               clear_s = 1'b1;
            end else if (bus.rdy_in && bus.if_req_in && !bus.flush_in) begin
               state_d = READ;
               owner_d = OWN_IF;
               base_d  = bus.if_addr_in;
               len_d   = LEN_4;
               clear_s = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if ((owner_q == OWN_IF) && bus.flush_in) begin
               // Redirect: drop the fetch and any partially assembled word
               state_d = IDLE;
               clear_s = 1'b1;
            end else if (pend_s && (idx_s == len_q)) begin
               state_d = IDLE;
               clear_s = 1'b1;
               if (owner_q == OWN_IF) begin
                  if_done_d = 1'b1;
                  if_inst_d = asm_s;
               end else begin
                  mem_done_d  = 1'b1;
                  mem_rdata_d = asm_s;
               end
            end else begin
               step_s = bus.rdy_in && (idx_s < len_q);
            end
         end
         WRITE: begin
            step_s = bus.rdy_in;
            if (bus.rdy_in && (idx_s == (len_q - 3'd1))) begin
               state_d    = IDLE;
               clear_s    = 1'b1;
               mem_done_d = 1'b1;
            end else begin
               state_d = WRITE;
            end
         end
         default: begin
            state_d = IDLE;
            clear_s = 1'b1;
         end
      endcase
   end

   // Transaction and result registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         base_q      <= 32'd0;
         len_q       <= 3'd0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_inst_q   <= 32'd0;
         mem_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         base_q      <= base_d;
         len_q       <= len_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         if_inst_q   <= if_inst_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign bus.ram_a_out     = (state_q == IDLE) ? 32'd0 : base_q + {29'd0, idx_s};
   assign bus.ram_dout_out  = (state_q == WRITE) ? wbyte_s : 8'd0;
   assign bus.ram_wr_out    = bus.rdy_in && (state_q == WRITE);
   assign bus.if_done_out   = if_done_q;
   assign bus.if_inst_out   = if_inst_q;
   assign bus.mem_done_out  = mem_done_q;
   assign bus.mem_rdata_out = mem_rdata_q;
   assign bus.busy_if_out   = (state_q != IDLE) && (owner_q == OWN_IF);
   assign bus.busy_mem_out  = (state_q != IDLE) && (owner_q == OWN_MEM);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a one-cycle-latency RAM model.
module tb_ram_port_arbiter;
   logic clk_in;
   logic rst_in;
   int   n_tests;
   int   n_fail;
   logic [31:0] wr_addr_log[$];
   logic [7:0]  wr_data_log[$];
   int   wr_snap;

   ram_port_arbiter_if bus ();

   ram_port_arbiter dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Fixed memory image; IO space reads back 0x41
   function automatic logic [7:0] rom(input logic [31:0] a);
      logic [7:0] b;
      if (a[17:16] == 2'b11) begin
         b = 8'h41;
      end else begin
         case (a)
            32'h100: b = 8'h13;
            32'h101: b = 8'h05;
            32'h102: b = 8'hA0;
            32'h103: b = 8'h00;
            32'h400: b = 8'h44;
            32'h401: b = 8'h33;
            32'h402: b = 8'h22;
            32'h403: b = 8'h11;
            32'h500: b = 8'hEF;
            32'h501: b = 8'hBE;
            32'h502: b = 8'hAD;
            32'h503: b = 8'hDE;
            default: b = 8'h00;
         endcase
      end
      return b;
   endfunction

   // RAM: data valid the cycle after its address; writes are logged
   always @(posedge clk_in) begin
      bus.ram_din_in <= rom(bus.ram_a_out);
      if (bus.ram_wr_out) begin
         wr_addr_log.push_back(bus.ram_a_out);
         wr_data_log.push_back(bus.ram_dout_out);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_in  = 1'b0;
      bus.rdy_in       = 1'b1;
      bus.flush_in     = 1'b0;
      bus.if_req_in    = 1'b0;
      bus.if_addr_in   = 32'd0;
      bus.mem_req_in   = 1'b0;
      bus.mem_wr_in    = 1'b0;
      bus.mem_addr_in  = 32'd0;
      bus.mem_len_in   = 3'd0;
      bus.mem_wdata_in = 32'd0;

      // Reset state
      repeat (3) @(negedge clk_in);
      chk("rst_a", bus.ram_a_out, 32'd0);
      chk("rst_wr", {31'd0, bus.ram_wr_out}, 32'd0);
      chk("rst_busy", {30'd0, bus.busy_if_out, bus.busy_mem_out}, 32'd0);
      chk("rst_inst", bus.if_inst_out, 32'd0);
      rst_in = 1'b1;
      @(negedge clk_in);

      // 1: 4-byte fetch from 0x100
      bus.if_addr_in = 32'h100;
      bus.if_req_in  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_in);
         chk("t1_addr", bus.ram_a_out, 32'h100 + 32'(k));
         chk("t1_wr", {31'd0, bus.ram_wr_out}, 32'd0);
      end
      chk("t1_busy", {31'd0, bus.busy_if_out}, 32'd1);
      @(negedge clk_in);
      chk("t1_early", {31'd0, bus.if_done_out}, 32'd0);
      @(negedge clk_in);
      chk("t1_done", {31'd0, bus.if_done_out}, 32'd1);
      chk("t1_inst", bus.if_inst_out, 32'h00A00513);
      bus.if_req_in = 1'b0;
      @(negedge clk_in);
      chk("t1_drop", {31'd0, bus.if_done_out}, 32'd0);

      // 2: simultaneous store and fetch, MEM wins
      bus.mem_req_in   = 1'b1;
      bus.mem_wr_in    = 1'b1;
      bus.mem_len_in   = 3'd2;
      bus.mem_addr_in  = 32'h200;
      bus.mem_wdata_in = 32'h0000BEEF;
      bus.if_req_in    = 1'b1;
      @(negedge clk_in);
      chk("t2_a0", bus.ram_a_out, 32'h200);
      chk("t2_d0", {24'd0, bus.ram_dout_out}, 32'hEF);
      chk("t2_wr0", {31'd0, bus.ram_wr_out}, 32'd1);
      chk("t2_owner", {30'd0, bus.busy_if_out, bus.busy_mem_out}, 32'd1);
      @(negedge clk_in);
      chk("t2_a1", bus.ram_a_out, 32'h201);
      chk("t2_d1", {24'd0, bus.ram_dout_out}, 32'hBE);
      @(negedge clk_in);
      chk("t2_done", {31'd0, bus.mem_done_out}, 32'd1);
      chk("t2_wr_end", {31'd0, bus.ram_wr_out}, 32'd0);
      bus.mem_req_in = 1'b0;
      @(negedge clk_in);
      chk("t2_if_acc", {31'd0, bus.busy_if_out}, 32'd1);
      chk("t2_if_a", bus.ram_a_out, 32'h100);
      repeat (4) @(negedge clk_in);
      chk("t2_if_early", {31'd0, bus.if_done_out}, 32'd1 - 32'd1);
      @(negedge clk_in);
      chk("t2_if_done", {31'd0, bus.if_done_out}, 32'd1);
      chk("t2_if_inst", bus.if_inst_out, 32'h00A00513);
      bus.if_req_in = 1'b0;
      chk("t2_nwr", 32'(wr_addr_log.size()), 32'd2);
      if (wr_addr_log.size() == 2) begin
         chk("t2_log_a1", wr_addr_log[1], 32'h201);
         chk("t2_log_d1", {24'd0, wr_data_log[1]}, 32'hBE);
      end else begin
         chk("t2_log_present", 32'(wr_addr_log.size()), 32'd2);
      end

      // 3: 1-byte load from IO space
      @(negedge clk_in);
      bus.mem_req_in  = 1'b1;
      bus.mem_wr_in   = 1'b0;
      bus.mem_len_in  = 3'd1;
      bus.mem_addr_in = 32'h30000;
      @(negedge clk_in);
      chk("t3_a", bus.ram_a_out, 32'h30000);
      @(negedge clk_in);
      chk("t3_early", {31'd0, bus.mem_done_out}, 32'd0);
      @(negedge clk_in);
      chk("t3_done", {31'd0, bus.mem_done_out}, 32'd1);
      chk("t3_data", bus.mem_rdata_out, 32'h00000041);
      bus.mem_req_in = 1'b0;

      // 4: fetch flushed at E2, refetch from 0x400
      @(negedge clk_in);
      bus.if_addr_in = 32'h100;
      bus.if_req_in  = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      bus.flush_in   = 1'b1;
      bus.if_addr_in = 32'h400;
      @(negedge clk_in);
      chk("t4_idle", {31'd0, bus.busy_if_out}, 32'd0);
      chk("t4_a_idle", bus.ram_a_out, 32'd0);
      chk("t4_nodone", {31'd0, bus.if_done_out}, 32'd0);
      bus.flush_in = 1'b0;
      @(negedge clk_in);
      chk("t4_a", bus.ram_a_out, 32'h400);
      chk("t4_busy", {31'd0, bus.busy_if_out}, 32'd1);
      repeat (4) @(negedge clk_in);
      chk("t4_early", {31'd0, bus.if_done_out}, 32'd0);
      @(negedge clk_in);
      chk("t4_done", {31'd0, bus.if_done_out}, 32'd1);
      chk("t4_inst", bus.if_inst_out, 32'h11223344);
      bus.if_req_in = 1'b0;

      // 5: 4-byte load with rdy low for three cycles after E2
      @(negedge clk_in);
      bus.mem_req_in  = 1'b1;
      bus.mem_wr_in   = 1'b0;
      bus.mem_len_in  = 3'd4;
      bus.mem_addr_in = 32'h500;
      @(negedge clk_in);
      chk("t5_a0", bus.ram_a_out, 32'h500);
      @(negedge clk_in);
      chk("t5_a1", bus.ram_a_out, 32'h501);
      @(negedge clk_in);
      bus.rdy_in = 1'b0;
      chk("t5_hold3", bus.ram_a_out, 32'h502);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_in);
         chk("t5_hold", bus.ram_a_out, 32'h502);
         chk("t5_wr", {31'd0, bus.ram_wr_out}, 32'd0);
         chk("t5_nodone", {31'd0, bus.mem_done_out}, 32'd0);
      end
      @(negedge clk_in);
      bus.rdy_in = 1'b1;
      chk("t5_hold6", bus.ram_a_out, 32'h502);
      @(negedge clk_in);
      chk("t5_a3", bus.ram_a_out, 32'h503);
      @(negedge clk_in);
      chk("t5_early", {31'd0, bus.mem_done_out}, 32'd0);
      @(negedge clk_in);
      chk("t5_done", {31'd0, bus.mem_done_out}, 32'd1);
      chk("t5_data", bus.mem_rdata_out, 32'hDEADBEEF);
      bus.mem_req_in = 1'b0;

      // 6: asynchronous reset in the middle of a store
      @(negedge clk_in);
      bus.mem_req_in   = 1'b1;
      bus.mem_wr_in    = 1'b1;
      bus.mem_len_in   = 3'd4;
      bus.mem_addr_in  = 32'h600;
      bus.mem_wdata_in = 32'hCAFEF00D;
      wr_snap = wr_addr_log.size();
      @(negedge clk_in);
      chk("t6_a0", bus.ram_a_out, 32'h600);
      chk("t6_d0", {24'd0, bus.ram_dout_out}, 32'h0D);
      @(negedge clk_in);
      chk("t6_a1", bus.ram_a_out, 32'h601);
      chk("t6_wr1", {31'd0, bus.ram_wr_out}, 32'd1);
      #2;
      rst_in = 1'b0;
      #1;
      chk("t6_wr", {31'd0, bus.ram_wr_out}, 32'd0);
      chk("t6_a", bus.ram_a_out, 32'd0);
      chk("t6_dout", {24'd0, bus.ram_dout_out}, 32'd0);
      chk("t6_busy", {31'd0, bus.busy_mem_out}, 32'd0);
      chk("t6_inst", bus.if_inst_out, 32'd0);
      chk("t6_rdata", bus.mem_rdata_out, 32'd0);
      bus.mem_req_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      repeat (5) @(negedge clk_in);
      chk("t6_nwr", 32'(wr_addr_log.size()), 32'(wr_snap + 1));
      chk("t6_done", {31'd0, bus.mem_done_out}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
